// File: rtl/midi_rx_ctrl_if.sv
// Serial input and shift-register control bundle of the MIDI receive sequencer.
// framing_err is present only when MIDI_RX_FRAMING_ERR_EN is defined.
interface midi_rx_ctrl_if;
  logic rx;
  logic shift_en;
  logic shift_in;
  logic byte_valid;
  logic busy;
`ifdef MIDI_RX_FRAMING_ERR_EN
  logic framing_err;

  modport master (input rx, output shift_en, shift_in, byte_valid, busy, framing_err);
  modport slave  (output rx, input shift_en, shift_in, byte_valid, busy, framing_err);
`else
  modport master (input rx, output shift_en, shift_in, byte_valid, busy);
  modport slave  (output rx, input shift_en, shift_in, byte_valid, busy);
`endif
endinterface

// File: rtl/midi_rx_ctrl.sv
// MIDI 8N1 receive sequencer: synchronises rx, times bit centres, drives an external right-shift register.
// Optional framing_err output enabled by defining MIDI_RX_FRAMING_ERR_EN.
module midi_rx_ctrl #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic           clk,
  input  logic           reset,
  midi_rx_ctrl_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic             shift_en;
  logic             byte_valid;

  // Both flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    byte_valid  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          timer_nxt = '0;
        end
      end

      START: begin
        if (timer == HALF_LAST) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end

      // Timer was re-zeroed at the start-bit centre, so each wrap lands on a data-bit centre.
      DATA: begin
        if (timer == BIT_LAST) begin
          shift_en    = 1'b1;
          timer_nxt   = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end

      STOP: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          if (rx_s) begin
            byte_valid = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = BREAK;
          end
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end

      // A line held low must return high before a new start bit can be recognised.
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  assign bus.shift_en   = shift_en;
  assign bus.shift_in   = rx_s;
  assign bus.byte_valid = byte_valid;
  assign bus.busy       = (state != IDLE);

`ifdef MIDI_RX_FRAMING_ERR_EN
  assign bus.framing_err = (state == STOP) && (timer == BIT_LAST) && !rx_s;
`endif

endmodule
